// File: rtl/write_memory.sv
// Sequential BRAM writer: streams DATA_W-bit words into consecutive RAM addresses from base_addr for 'length' words.
// Latency: a beat accepted at edge N appears on ena/wea/addra/dina in cycle N+1; done coincides with the last write.
// Backpressure: s_ready is high only in RUN; s_valid gaps produce no write and do not advance the address.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, base_addr, length transfer request and its parameters (sampled in IDLE only)
//   s_valid, s_data, s_ready input word stream
//   ena, wea, addra, dina    registered BRAM port A write interface
//   busy, done, wrapped      status: RUN state, last-write pulse, sticky address wrap
module write_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   remaining;
    logic              beat;

    // Status outputs decode straight from the state register.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        beat      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (length == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                beat    = s_valid;
                if (s_valid && (remaining == REM_ONE)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
            ena       <= 1'b0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            wrapped   <= 1'b0;
        end else begin
            state <= state_nxt;
            ena   <= beat;
            wea   <= beat;
            if ((state == IDLE) && start) begin
                addr_cnt  <= base_addr;
                remaining <= length;
                wrapped   <= 1'b0;
            end
            if (beat) begin
                addra     <= addr_cnt;
                dina      <= s_data;
                addr_cnt  <= addr_cnt + ADDR_ONE;
                remaining <= remaining - REM_ONE;
                // The post-increment after the final beat is never used for a write,
                // so a full-RAM fill from address 0 does not count as a wrap.
                if ((addr_cnt == ADDR_MAX) && (remaining != REM_ONE)) begin
                    wrapped <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_write_memory.sv
// Testbench for write_memory: randomized transfers checked against an address/data reference model.
// Latency: expects each accepted beat to appear as a write one cycle later, done on the last write.
// Backpressure: drives random or patterned s_valid gaps and injects stray start/s_valid.
module tb_write_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        ena;
    logic        wea;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic        busy;
    logic        done;
    logic        wrapped;

    write_memory #(.DATA_W(16), .ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .ena       (ena),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .busy      (busy),
        .done      (done),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    // Observed RAM contents and write log, captured from the BRAM port.
    logic [15:0] ram [1024];
    logic [9:0]  wq_addr [$];
    logic [15:0] wq_data [$];
    logic        mon_on = 1'b0;
    int          done_cnt;
    int          done_cyc;
    int          ena_bad;
    logic        busy_seen;
    logic        done_wea;

    // Stimulus controls
    logic        use_seq = 1'b0;
    logic        pat [8];
    int          pat_len = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (wea) begin
                wq_addr.push_back(addra);
                wq_data.push_back(dina);
                ram[addra] = dina;
            end
            if (ena !== wea) ena_bad++;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_wea = wea;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        ena_bad   = 0;
        busy_seen = 1'b0;
        done_wea  = 1'b0;
    endtask

    // One full transfer; called just after a rising edge (#1).
    task automatic run_xfer(input logic [9:0] base, input int len, input int pct, input int inj_at);
        logic [15:0] d [$];
        int   idx, step, bad, start_cyc, acc_cyc;
        logic rdy, exp_wrap, inj_done;
        for (int i = 0; i < len; i++) begin
            d.push_back(use_seq ? 16'(16'hA001 + i) : 16'($urandom));
        end
        clear_mon();
        // s_valid alongside start must not be accepted.
        start     = 1'b1;
        base_addr = base;
        length    = 11'(len);
        s_valid   = 1'b1;
        s_data    = 16'hDEAD;
        @(posedge clk); #1;
        start_cyc = cyc;
        acc_cyc   = cyc;
        start     = 1'b0;
        s_valid   = 1'b0;
        idx       = 0;
        step      = 0;
        inj_done  = 1'b0;
        while (idx < len && step < 5000) begin
            if (pat_len > 0) s_valid = (step < pat_len) ? pat[step] : 1'b1;
            else             s_valid = ($urandom_range(99) < pct);
            s_data = d[idx];
            if (idx == inj_at && !inj_done) begin
                start     = 1'b1;
                base_addr = 10'h200;
                length    = 11'd7;
                inj_done  = 1'b1;
            end
            rdy = s_ready;
            @(posedge clk); #1;
            if (s_valid && rdy) begin
                idx++;
                acc_cyc = cyc;
            end
            start = 1'b0;
            step++;
        end
        s_valid = 1'b0;
        chk("stream_accepted", idx, len);
        repeat (3) @(posedge clk);
        #1;

        exp_wrap = 1'b0;
        for (int i = 0; i < len - 1; i++) begin
            if (((int'(base) + i) % 1024) == 1023) exp_wrap = 1'b1;
        end

        chk("num_writes", wq_addr.size(), len);
        bad = 0;
        for (int i = 0; i < wq_addr.size() && i < len; i++) begin
            if (wq_addr[i] !== 10'((int'(base) + i) % 1024) || wq_data[i] !== d[i]) bad++;
        end
        chk("write_seq", bad, 0);
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (ram[10'((int'(base) + i) % 1024)] !== d[i]) bad++;
        end
        chk("readback", bad, 0);
        chk("done_count", done_cnt, 1);
        chk("busy_seen", busy_seen, (len != 0));
        chk("ena_eq_wea", ena_bad, 0);
        chk("idle_status", {busy, s_ready, done}, 0);
        if (len != 0) begin
            chk("done_on_last_wr", done_wea, 1);
            chk("done_cycle", done_cyc, acc_cyc);
            chk("wrapped", wrapped, exp_wrap);
        end else begin
            chk("done_lat_zero", (done_cyc >= start_cyc) && (done_cyc - start_cyc <= 2), 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        logic r;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {s_ready, ena, wea, busy, done, wrapped}, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 0);
        rst    = 1'b0;
        mon_on = 1'b1;
        @(posedge clk); #1;

        // T1 basic
        use_seq = 1'b1;
        run_xfer(10'h010, 4, 100, -1);
        use_seq = 1'b0;

        // T2 backpressure pattern
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
        pat_len = 6;
        run_xfer(10'h123, 3, 100, -1);
        pat_len = 0;

        // T3 wrap, sticky until next start
        run_xfer(10'h3FE, 4, 100, -1);
        repeat (5) @(posedge clk);
        #1;
        chk("wrap_hold", wrapped, 1);
        run_xfer(10'h3FE, 2, 100, -1);

        // T4 zero length
        run_xfer(10'h055, 0, 100, -1);

        // T5 start while busy
        run_xfer(10'h050, 6, 100, 2);

        // T6 reset mid-operation
        clear_mon();
        start     = 1'b1;
        base_addr = 10'h0A0;
        length    = 11'd5;
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b1;
        acc     = 0;
        for (int k = 0; k < 20 && acc < 2; k++) begin
            s_data = 16'(16'h5000 + acc);
            r = s_ready;
            @(posedge clk); #1;
            if (r) acc++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_status", {wea, ena, busy, s_ready, done}, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("rstmid_writes", wq_addr.size(), 2);
        chk("rstmid_no_done", done_cnt, 0);
        run_xfer(10'h0A7, 1, 100, -1);

        // Full-RAM fills
        run_xfer(10'h000, 1024, 100, -1);
        run_xfer(10'(1 + $urandom_range(1022)), 1024, 90, -1);

        // Randomized transfers
        for (int t = 0; t < 16; t++) begin
            run_xfer(10'($urandom_range(1023)), $urandom_range(24), $urandom_range(40, 100),
                     ($urandom_range(3) == 0) ? 1 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
